// File: rtl/forward_resolver.sv
// forward_resolver
//   Forwarding-decision stage between the ingress packet buffer and the
//   per-egress write queues. Each accepted frame descriptor triggers an
//   address-table lookup; the result becomes a unicast, flood (ingress port
//   excluded) or drop decision. Unicast/flood decisions are queued and
//   delivered to egress ports through a per-port valid/ready handshake.
//   Drops are reported as a one-cycle pulse.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o         descriptor handshake (ready is credit based)
//   req_start_ptr_i                 buffer start pointer of the frame
//   req_dest_addr_i                 destination MAC (first octet in [47:40])
//   req_src_port_i                  ingress port
//   lookup_en_o/lookup_addr_o       address-table lookup strobe and key
//   lookup_hit_i/lookup_port_i      table result, LOOKUP_LAT cycles after strobe
//   write_reqs_o/port_ready_i       per-egress request / accept
//   start_ptr_o, flood_o            head decision pointer and flood flag
//   drop_valid_o, drop_ptr_o        drop pulse and pointer to free
//   unicast_cnt_o, flood_cnt_o, drop_cnt_o  wrapping decision counters
module forward_resolver #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 12,
  parameter int LOOKUP_LAT = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ADDR_W-1:0]            req_start_ptr_i,
  input  logic [47:0]                  req_dest_addr_i,
  input  logic [$clog2(NUM_PORTS)-1:0] req_src_port_i,
  output logic                         lookup_en_o,
  output logic [47:0]                  lookup_addr_o,
  input  logic                         lookup_hit_i,
  input  logic [$clog2(NUM_PORTS)-1:0] lookup_port_i,
  output logic [NUM_PORTS-1:0]         write_reqs_o,
  input  logic [NUM_PORTS-1:0]         port_ready_i,
  output logic [ADDR_W-1:0]            start_ptr_o,
  output logic                         flood_o,
  output logic                         drop_valid_o,
  output logic [ADDR_W-1:0]            drop_ptr_o,
  output logic [CNT_W-1:0]             unicast_cnt_o,
  output logic [CNT_W-1:0]             flood_cnt_o,
  output logic [CNT_W-1:0]             drop_cnt_o
);

  localparam int PW  = $clog2(NUM_PORTS);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int OW  = $clog2(FIFO_DEPTH + 1);

  function automatic logic [NUM_PORTS-1:0] port_bit(input logic [PW-1:0] p);
    logic [NUM_PORTS-1:0] r;
    for (int i = 0; i < NUM_PORTS; i++) r[i] = (p == PW'(i));
    return r;
  endfunction

  logic                 accept;
  logic                 vld_p [0:LOOKUP_LAT];
  logic [ADDR_W-1:0]    ptr_p [0:LOOKUP_LAT];
  logic [PW-1:0]        src_p [0:LOOKUP_LAT];
  logic                 grp_p [0:LOOKUP_LAT];

  logic                 d_vld, d_flood, d_uni, d_drop, d_enq;
  logic [NUM_PORTS-1:0] d_mask;

  logic [NUM_PORTS-1:0] fifo_mask  [FIFO_DEPTH];
  logic [ADDR_W-1:0]    fifo_ptr   [FIFO_DEPTH];
  logic                 fifo_flood [FIFO_DEPTH];
  logic [FAW:0]         wr_idx, rd_idx;
  logic                 fifo_empty, push, pop, bypass;

  logic [NUM_PORTS-1:0] remain;
  logic                 head_free, retire;
  logic [OW-1:0]        out_q, out_next;

  assign accept = req_valid_i && req_ready_o;

  // ---- stage p0..pLAT: lookup strobe and tag pipeline ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_en_o   <= 1'b0;
      lookup_addr_o <= '0;
      for (int k = 0; k <= LOOKUP_LAT; k++) vld_p[k] <= 1'b0;
    end else begin
      lookup_en_o <= accept;
      vld_p[0]    <= accept;
      if (accept) lookup_addr_o <= req_dest_addr_i;
      for (int k = 1; k <= LOOKUP_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ptr_p[0] <= req_start_ptr_i;
      src_p[0] <= req_src_port_i;
      grp_p[0] <= req_dest_addr_i[40];
    end
    for (int k = 1; k <= LOOKUP_LAT; k++) begin
      ptr_p[k] <= ptr_p[k-1];
      src_p[k] <= src_p[k-1];
      grp_p[k] <= grp_p[k-1];
    end
  end

  // ---- decision: table result meets the last tag stage ----
  always_comb begin
    d_vld   = vld_p[LOOKUP_LAT];
    d_flood = d_vld && (grp_p[LOOKUP_LAT] || !lookup_hit_i);
    d_uni   = d_vld && !grp_p[LOOKUP_LAT] && lookup_hit_i &&
              (lookup_port_i != src_p[LOOKUP_LAT]);
    d_drop  = d_vld && !grp_p[LOOKUP_LAT] && lookup_hit_i &&
              (lookup_port_i == src_p[LOOKUP_LAT]);
    d_enq   = d_flood || d_uni;
    d_mask  = d_flood ? ~port_bit(src_p[LOOKUP_LAT]) : port_bit(lookup_port_i);
  end

  // Head is free when nothing is left pending after this edge's accepts;
  // it then refills from the FIFO, or directly from a new decision.
  always_comb begin
    remain     = write_reqs_o & ~port_ready_i;
    head_free  = (remain == '0);
    retire     = (write_reqs_o != '0) && head_free;
    fifo_empty = (wr_idx == rd_idx);
    pop        = head_free && !fifo_empty;
    bypass     = head_free && fifo_empty && d_enq;
    push       = d_enq && !bypass;
    out_next   = out_q + OW'(accept) - OW'(d_drop) - OW'(retire);
  end

  // ---- decision queue storage ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mask[wr_idx[FAW-1:0]]  <= d_mask;
      fifo_ptr[wr_idx[FAW-1:0]]   <= ptr_p[LOOKUP_LAT];
      fifo_flood[wr_idx[FAW-1:0]] <= d_flood;
    end
  end

  // ---- head stage, credits, drop pulse, counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx        <= '0;
      rd_idx        <= '0;
      write_reqs_o  <= '0;
      start_ptr_o   <= '0;
      flood_o       <= 1'b0;
      out_q         <= '0;
      req_ready_o   <= 1'b0;
      drop_valid_o  <= 1'b0;
      drop_ptr_o    <= '0;
      unicast_cnt_o <= '0;
      flood_cnt_o   <= '0;
      drop_cnt_o    <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;

      if (pop) begin
        write_reqs_o <= fifo_mask[rd_idx[FAW-1:0]];
        start_ptr_o  <= fifo_ptr[rd_idx[FAW-1:0]];
        flood_o      <= fifo_flood[rd_idx[FAW-1:0]];
      end else if (bypass) begin
        write_reqs_o <= d_mask;
        start_ptr_o  <= ptr_p[LOOKUP_LAT];
        flood_o      <= d_flood;
      end else begin
        write_reqs_o <= remain;
      end

      // Outstanding = in-flight lookups + queued decisions + busy head.
      out_q       <= out_next;
      req_ready_o <= (out_next < OW'(FIFO_DEPTH));

      drop_valid_o <= d_drop;
      if (d_drop) drop_ptr_o <= ptr_p[LOOKUP_LAT];

      if (d_uni)   unicast_cnt_o <= unicast_cnt_o + 1'b1;
      if (d_flood) flood_cnt_o   <= flood_cnt_o + 1'b1;
      if (d_drop)  drop_cnt_o    <= drop_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_forward_resolver.sv
module tb_forward_resolver;
  localparam int NP  = 4;
  localparam int AW  = 12;
  localparam int LAT = 2;
  localparam int FD  = 4;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_start_ptr_i;
  logic [47:0]   req_dest_addr_i;
  logic [1:0]    req_src_port_i;
  logic          lookup_en_o;
  logic [47:0]   lookup_addr_o;
  logic          lookup_hit_i;
  logic [1:0]    lookup_port_i;
  logic [NP-1:0] write_reqs_o;
  logic [NP-1:0] port_ready_i;
  logic [AW-1:0] start_ptr_o;
  logic          flood_o;
  logic          drop_valid_o;
  logic [AW-1:0] drop_ptr_o;
  logic [CW-1:0] unicast_cnt_o, flood_cnt_o, drop_cnt_o;

  always #5 clk = ~clk;

  forward_resolver #(
    .NUM_PORTS(NP), .ADDR_W(AW), .LOOKUP_LAT(LAT), .FIFO_DEPTH(FD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_start_ptr_i(req_start_ptr_i), .req_dest_addr_i(req_dest_addr_i),
    .req_src_port_i(req_src_port_i),
    .lookup_en_o(lookup_en_o), .lookup_addr_o(lookup_addr_o),
    .lookup_hit_i(lookup_hit_i), .lookup_port_i(lookup_port_i),
    .write_reqs_o(write_reqs_o), .port_ready_i(port_ready_i),
    .start_ptr_o(start_ptr_o), .flood_o(flood_o),
    .drop_valid_o(drop_valid_o), .drop_ptr_o(drop_ptr_o),
    .unicast_cnt_o(unicast_cnt_o), .flood_cnt_o(flood_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  typedef struct {
    logic [NP-1:0] mask;
    logic [AW-1:0] ptr;
    logic          flood;
  } hd_t;

  hd_t           exp_head_q[$];
  logic [AW-1:0] exp_drop_q[$];
  int            tbl_port [logic [47:0]];
  int            n_chk = 0;
  int            n_pass = 0;
  int            exp_uni = 0, exp_fl = 0, exp_dr = 0;
  bit            in_head = 0;
  logic [NP-1:0] rem_m = '0;

  // Address table behaviour: answers LAT cycles after each strobe.
  bit          pv [0:LAT];
  logic [47:0] pa [0:LAT];

  always @(posedge clk) begin
    int lp;
    #1;
    if (!rst_n) begin
      for (int k = 0; k <= LAT; k++) pv[k] = 1'b0;
      lookup_hit_i  = 1'b0;
      lookup_port_i = '0;
    end else begin
      for (int k = LAT; k >= 1; k--) begin
        pv[k] = pv[k-1];
        pa[k] = pa[k-1];
      end
      pv[0] = lookup_en_o;
      pa[0] = lookup_addr_o;
      if (pv[LAT]) begin
        lookup_hit_i = tbl_port.exists(pa[LAT]);
        if (lookup_hit_i) begin
          lp = tbl_port[pa[LAT]];
          lookup_port_i = 2'(lp);
        end else begin
          lookup_port_i = 2'($urandom);
        end
      end else begin
        lookup_hit_i  = 1'($urandom);
        lookup_port_i = 2'($urandom);
      end
    end
  end

  // Expected decision for an accepted descriptor, straight from the rules.
  task automatic model_accept(input logic [47:0] d, input int s, input logic [AW-1:0] p);
    hd_t h;
    int  lp;
    h.ptr = p;
    if (d[40]) begin
      h.mask = ~(NP'(1) << s); h.flood = 1'b1; exp_head_q.push_back(h); exp_fl++;
    end else if (tbl_port.exists(d)) begin
      lp = tbl_port[d];
      if (lp != s) begin
        h.mask = NP'(1) << lp; h.flood = 1'b0; exp_head_q.push_back(h); exp_uni++;
      end else begin
        exp_drop_q.push_back(p); exp_dr++;
      end
    end else begin
      h.mask = ~(NP'(1) << s); h.flood = 1'b1; exp_head_q.push_back(h); exp_fl++;
    end
  endtask

  // Track the head as seen by egress ports: bits clear when accepted.
  always @(posedge clk) begin
    if (rst_n && in_head) begin
      rem_m = rem_m & ~port_ready_i;
      if (rem_m == '0) in_head = 1'b0;
    end
  end

  // Scoreboard for drops and head decisions.
  always @(negedge clk) begin
    hd_t h;
    logic [AW-1:0] e;
    if (rst_n) begin
      if (drop_valid_o) begin
        n_chk++;
        if (exp_drop_q.size() == 0)
          $display("FAIL drop_unexpected: got ptr=%h, want no drop", drop_ptr_o);
        else begin
          e = exp_drop_q.pop_front();
          if (drop_ptr_o !== e) $display("FAIL drop_ptr: got %h want %h", drop_ptr_o, e);
          else n_pass++;
        end
      end
      if (in_head) begin
        n_chk++;
        if (write_reqs_o !== rem_m) $display("FAIL head_pending: got %b want %b", write_reqs_o, rem_m);
        else n_pass++;
      end else if (write_reqs_o !== '0) begin
        n_chk++;
        if (exp_head_q.size() == 0)
          $display("FAIL head_unexpected: got reqs=%b ptr=%h, want none", write_reqs_o, start_ptr_o);
        else begin
          h = exp_head_q.pop_front();
          if (write_reqs_o !== h.mask || start_ptr_o !== h.ptr || flood_o !== h.flood)
            $display("FAIL head: got mask=%b ptr=%h flood=%b want mask=%b ptr=%h flood=%b",
                     write_reqs_o, start_ptr_o, flood_o, h.mask, h.ptr, h.flood);
          else n_pass++;
          in_head = 1'b1;
          rem_m   = h.mask;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic offer(input logic [47:0] d, input int s, input logic [AW-1:0] p, output bit acc);
    req_valid_i     = 1'b1;
    req_dest_addr_i = d;
    req_src_port_i  = 2'(s);
    req_start_ptr_i = p;
    acc = req_ready_o;
    if (acc) model_accept(d, s, p);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    int i;
    port_ready_i = '1;
    req_valid_i  = 1'b0;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_head_q.size() == 0 && exp_drop_q.size() == 0 && !in_head) break;
    end
    repeat (LAT + 3) @(negedge clk);
    n_chk++;
    if (exp_head_q.size() != 0 || exp_drop_q.size() != 0 || in_head)
      $display("FAIL %s_drain: got heads_left=%0d drops_left=%0d, want 0", nm, exp_head_q.size(), exp_drop_q.size());
    else n_pass++;
    n_chk++;
    if (unicast_cnt_o !== CW'(exp_uni) || flood_cnt_o !== CW'(exp_fl) || drop_cnt_o !== CW'(exp_dr))
      $display("FAIL %s_counters: got u=%0d f=%0d d=%0d want u=%0d f=%0d d=%0d", nm,
               unicast_cnt_o, flood_cnt_o, drop_cnt_o, exp_uni, exp_fl, exp_dr);
    else n_pass++;
    n_chk++;
    if (req_ready_o !== 1'b1) $display("FAIL %s_ready_idle: got %b want 1", nm, req_ready_o);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = 1'b0; req_start_ptr_i = '0; req_dest_addr_i = '0;
    req_src_port_i = '0; port_ready_i = '0; lookup_hit_i = 1'b0; lookup_port_i = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (write_reqs_o !== '0 || req_ready_o !== 1'b0 || lookup_en_o !== 1'b0 ||
        drop_valid_o !== 1'b0 || flood_o !== 1'b0 || start_ptr_o !== '0)
      $display("FAIL reset_outputs: got reqs=%b rdy=%b len=%b drop=%b flood=%b ptr=%h want all 0",
               write_reqs_o, req_ready_o, lookup_en_o, drop_valid_o, flood_o, start_ptr_o);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready_o);
    else n_pass++;
    n_chk++;
    if (unicast_cnt_o !== '0 || flood_cnt_o !== '0 || drop_cnt_o !== '0)
      $display("FAIL reset_counters: got %0d %0d %0d want 0 0 0", unicast_cnt_o, flood_cnt_o, drop_cnt_o);
    else n_pass++;
  endtask

  task automatic test_unicast();
    logic [47:0] mac;
    bit acc;
    mac = 48'h02_00_00_00_00_05;
    tbl_port.delete();
    tbl_port[mac] = 2;
    port_ready_i = '0;
    offer(mac, 0, 12'h0A3, acc);
    n_chk++;
    if (acc !== 1'b1 || lookup_en_o !== 1'b1 || lookup_addr_o !== mac)
      $display("FAIL uni_lookup: got acc=%b en=%b addr=%h want 1 1 %h", acc, lookup_en_o, lookup_addr_o, mac);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_chk++;
    if (write_reqs_o !== 4'b0000) $display("FAIL uni_early: got %b want 0000", write_reqs_o);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (write_reqs_o !== 4'b0100 || start_ptr_o !== 12'h0A3 || flood_o !== 1'b0)
      $display("FAIL uni_head: got reqs=%b ptr=%h flood=%b want 0100 0a3 0", write_reqs_o, start_ptr_o, flood_o);
    else n_pass++;
    n_chk++;
    if (unicast_cnt_o !== CW'(exp_uni)) $display("FAIL uni_cnt: got %0d want %0d", unicast_cnt_o, exp_uni);
    else n_pass++;
    port_ready_i = 4'b0100;
    @(negedge clk);
    n_chk++;
    if (write_reqs_o !== 4'b0000) $display("FAIL uni_retire: got %b want 0000", write_reqs_o);
    else n_pass++;
    drain("uni");
  endtask

  task automatic test_miss_flood();
    bit acc;
    port_ready_i = '0;
    offer(48'h02_00_00_00_00_11, 1, 12'h155, acc);
    repeat (3) @(negedge clk);
    n_chk++;
    if (write_reqs_o !== 4'b1101 || flood_o !== 1'b1 || start_ptr_o !== 12'h155)
      $display("FAIL miss_head: got reqs=%b flood=%b ptr=%h want 1101 1 155", write_reqs_o, flood_o, start_ptr_o);
    else n_pass++;
    port_ready_i = 4'b0001;
    @(negedge clk);
    n_chk++;
    if (write_reqs_o !== 4'b1100) $display("FAIL miss_partial: got %b want 1100", write_reqs_o);
    else n_pass++;
    port_ready_i = 4'b1100;
    @(negedge clk);
    n_chk++;
    if (write_reqs_o !== 4'b0000) $display("FAIL miss_retire: got %b want 0000", write_reqs_o);
    else n_pass++;
    port_ready_i = '0;
    drain("miss");
  endtask

  task automatic test_broadcast();
    logic [47:0] mac;
    bit acc;
    mac = 48'hFF_FF_FF_FF_FF_FF;
    tbl_port[mac] = 3;
    port_ready_i = '0;
    offer(mac, 3, 12'h2C4, acc);
    repeat (3) @(negedge clk);
    n_chk++;
    if (write_reqs_o !== 4'b0111 || flood_o !== 1'b1 || drop_valid_o !== 1'b0)
      $display("FAIL bcast_head: got reqs=%b flood=%b drop=%b want 0111 1 0", write_reqs_o, flood_o, drop_valid_o);
    else n_pass++;
    drain("bcast");
  endtask

  task automatic test_filter();
    logic [47:0] mac;
    bit acc;
    mac = 48'h02_00_00_00_00_22;
    tbl_port[mac] = 2;
    port_ready_i = '0;
    offer(mac, 2, 12'h1FF, acc);
    repeat (3) @(negedge clk);
    n_chk++;
    if (drop_valid_o !== 1'b1 || drop_ptr_o !== 12'h1FF || write_reqs_o !== 4'b0000)
      $display("FAIL filter_drop: got drop=%b ptr=%h reqs=%b want 1 1ff 0000", drop_valid_o, drop_ptr_o, write_reqs_o);
    else n_pass++;
    n_chk++;
    if (drop_cnt_o !== CW'(exp_dr)) $display("FAIL filter_cnt: got %0d want %0d", drop_cnt_o, exp_dr);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (drop_valid_o !== 1'b0) $display("FAIL filter_pulse: got %b want 0", drop_valid_o);
    else n_pass++;
    drain("filter");
  endtask

  task automatic test_backpressure();
    logic [47:0] mac;
    int n_acc;
    mac = 48'h02_00_00_00_00_33;
    tbl_port[mac] = 1;
    port_ready_i = '0;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      req_valid_i     = 1'b1;
      req_dest_addr_i = mac;
      req_src_port_i  = 2'd0;
      req_start_ptr_i = AW'(12'h100 + i);
      if (req_ready_o) begin
        model_accept(mac, 0, AW'(12'h100 + i));
        n_acc++;
      end
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    n_chk++;
    if (n_acc !== FD) $display("FAIL bp_accepted: got %0d want %0d", n_acc, FD);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_chk++;
    if (req_ready_o !== 1'b0) $display("FAIL bp_ready_held: got %b want 0", req_ready_o);
    else n_pass++;
    port_ready_i = '1;
    @(negedge clk);
    n_chk++;
    if (req_ready_o !== 1'b1) $display("FAIL bp_ready_return: got %b want 1", req_ready_o);
    else n_pass++;
    drain("bp");
  endtask

  task automatic test_random();
    logic [47:0] pool [8];
    logic [47:0] d;
    int s;
    logic [AW-1:0] p;
    tbl_port.delete();
    for (int i = 0; i < 6; i++) pool[i] = {8'h02, 32'h0, 8'(i)};
    pool[6] = 48'h01_00_5E_00_00_01;
    pool[7] = 48'hFF_FF_FF_FF_FF_FF;
    for (int i = 0; i < 8; i++)
      if ($urandom_range(1, 0) == 1) tbl_port[pool[i]] = int'($urandom_range(NP - 1, 0));
    for (int c = 0; c < 400; c++) begin
      port_ready_i = NP'($urandom);
      if ($urandom_range(3, 0) != 0) begin
        d = pool[$urandom_range(7, 0)];
        s = int'($urandom_range(NP - 1, 0));
        p = AW'($urandom);
        req_valid_i     = 1'b1;
        req_dest_addr_i = d;
        req_src_port_i  = 2'(s);
        req_start_ptr_i = p;
        if (req_ready_o) model_accept(d, s, p);
      end else begin
        req_valid_i = 1'b0;
      end
      @(negedge clk);
    end
    drain("rand");
  endtask

  task automatic test_reset_midflight();
    logic [47:0] mac;
    bit acc;
    mac = 48'h02_00_00_00_00_44;
    tbl_port[mac] = 1;
    port_ready_i = '1;
    offer(mac, 0, 12'h301, acc);
    req_valid_i = 1'b1;
    offer(mac, 0, 12'h302, acc);
    req_valid_i = 1'b1;
    offer(mac, 0, 12'h303, acc);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (write_reqs_o !== '0 || lookup_en_o !== 1'b0 || drop_valid_o !== 1'b0 || req_ready_o !== 1'b0 ||
        unicast_cnt_o !== '0 || flood_cnt_o !== '0 || drop_cnt_o !== '0)
      $display("FAIL midrst_outputs: got reqs=%b len=%b drop=%b rdy=%b cnt=%0d/%0d/%0d want all 0",
               write_reqs_o, lookup_en_o, drop_valid_o, req_ready_o, unicast_cnt_o, flood_cnt_o, drop_cnt_o);
    else n_pass++;
    exp_head_q.delete();
    exp_drop_q.delete();
    in_head = 1'b0;
    exp_uni = 0; exp_fl = 0; exp_dr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (write_reqs_o !== '0 || drop_valid_o !== 1'b0)
        $display("FAIL midrst_stale: got reqs=%b drop=%b want 0 0", write_reqs_o, drop_valid_o);
      else n_pass++;
    end
    n_chk++;
    if (unicast_cnt_o !== '0 || flood_cnt_o !== '0 || drop_cnt_o !== '0 || req_ready_o !== 1'b1)
      $display("FAIL midrst_after: got cnt=%0d/%0d/%0d rdy=%b want 0/0/0 1",
               unicast_cnt_o, flood_cnt_o, drop_cnt_o, req_ready_o);
    else n_pass++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unicast();
    test_miss_flood();
    test_broadcast();
    test_filter();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/forward_resolver.md
# forward_resolver

Second-generation forwarding-decision stage of the Ethernet switch, between the ingress packet buffer and the per-egress-port write queues. It accepts one stored frame per cycle, consisting of the buffer start pointer, destination MAC and ingress port. It issues an address-table lookup and turns the result into a unicast, flood (ingress port excluded), or drop decision. Decisions queue internally and are delivered to egress ports over a per-port valid/ready handshake, with credit-based backpressure toward ingress.

## Interface
- NUM_PORTS, 4: switch ports; ≥2.
- ADDR_W, 12: packet-buffer pointer width.
- LOOKUP_LAT, 2: fixed address-table latency in cycles; ≥1.
- FIFO_DEPTH, 4: decision queue depth; power of two, ≥2.
- CNT_W, 32: statistics counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  frame descriptor offered.
- req_ready_o  out  1  descriptor accepted when valid&&ready.
- req_start_ptr_i  in  ADDR_W  buffer start pointer.
- req_dest_addr_i  in  48  destination MAC, first octet in [47:40].
- req_src_port_i  in  $clog2(NUM_PORTS)  ingress port.
- lookup_en_o  out  1  table lookup strobe.
- lookup_addr_o  out  48  MAC being looked up.
- lookup_hit_i  in  1  table hit, valid LOOKUP_LAT cycles after strobe.
- lookup_port_i  in  $clog2(NUM_PORTS)  learned port on hit.
- write_reqs_o  out  NUM_PORTS  per-egress write request.
- port_ready_i  in  NUM_PORTS  per-egress accept.
- start_ptr_o  out  ADDR_W  pointer of the head decision, shared by all ports.
- flood_o  out  1  head decision is a flood.
- drop_valid_o  out  1  one-cycle drop pulse.
- drop_ptr_o  out  ADDR_W  pointer to free on drop.
- unicast_cnt_o, flood_cnt_o, drop_cnt_o  out  CNT_W  decision counters.

## Operation
- Accept edge E. lookup_en_o=1 and lookup_addr_o=dest during cycle E+1, registered. The start pointer, source port and a group flag (dest[40]) shift through a LOOKUP_LAT-deep tag pipeline alongside the lookup.
- The result is sampled at the end of cycle E+1+LOOKUP_LAT. Decision:
  - Group flag set → flood, regardless of hit.
  - Hit with lookup_port_i ≠ src → unicast, mask = one-hot(lookup_port_i).
  - Hit with lookup_port_i = src → drop (filter).
  - Miss → flood, mask = all ones with the src bit cleared.
- Drops are never queued. They assert drop_valid_o/drop_ptr_o for one cycle and increment drop_cnt_o.
- Unicast and flood decisions enter the decision FIFO as {mask, ptr, flood}.
- Head stage holds the pending mask. write_reqs_o = pending mask. Each bit clears on the edge where write_reqs_o[i]&&port_ready_i[i]. Requests are held stable until accepted, and ports complete independently.
- When the last pending bit clears, the next FIFO entry loads on the same edge, with no bubble. If the FIFO is empty but a decision arrives on that edge, the decision bypasses straight into the head stage.
- Credits: outstanding = in-flight lookups + FIFO count + (head busy). req_ready_o = outstanding < FIFO_DEPTH. The lookup pipeline never stalls.
- Counters increment by one per decision and wrap at 2^CNT_W.

## Timing
- Reset values: all outputs 0, pending mask 0, FIFO empty, counters 0. req_ready_o becomes 1 in the first cycle after rst_n deasserts.
- Reset mid-operation aborts in-flight lookups and queued decisions without issuing drop pulses; buffer reclamation is handled by the buffer manager's own reset.
- Latency with LOOKUP_LAT=2, empty queue, accept edge E: lookup_en_o during cycle E+1; write_reqs_o or drop_valid_o visible from cycle E+4.
- Throughput is one descriptor per cycle while credits are available.
- FIFO full plus in-flight work: req_ready_o=0 until a head retires. The credit freed by a retiring head is visible the following cycle.
- Simultaneous decision write and head retire with FIFO full is legal; count stays constant.
- port_ready_i on a port with no request is ignored.

## Test plan
- Hit on a different port: dest 02:00:00:00:00:05, src 0, hit port 2, ptr 0x0A3 → write_reqs_o=0100, start_ptr_o=0x0A3, flood_o=0 at cycle E+4; unicast_cnt_o=1.
- Miss: src 1, hit=0 → write_reqs_o=1101, flood_o=1. Hold port_ready_i=0001, then 1100 → the request bits clear in that order, and the head retires after the second accept.
- Broadcast FF:FF:FF:FF:FF:FF with hit=1 on port 3, src 3 → flood mask 0111, not a drop.
- Filter: hit port = src port 2, ptr 0x1FF → drop_valid_o pulse with drop_ptr_o=0x1FF, write_reqs_o stays 0, drop_cnt_o=1.
- Backpressure: port_ready_i=0, descriptors offered every cycle → exactly FIFO_DEPTH accepted, then req_ready_o=0. Release ports → ready returns one cycle after the first retire, and all pointers emerge in order.
- Assert rst_n low with three in flight → outputs 0 immediately; after release no stale write_reqs_o appear and counters read 0.
